// File: rtl/exec_ctrl.sv
// exec_ctrl: multi-cycle RV32I control FSM sequencing fetch, execute, memory and writeback.
module exec_ctrl (
  input  logic        clk,
  input  logic        rst,
  output logic        ifu_req_o,
  input  logic        ifu_ack_i,
  input  logic [31:0] ifu_inst_i,
  output logic        lsu_req_o,
  output logic        lsu_wen_o,
  input  logic        lsu_ack_i,
  output logic        alu_asel_o,
  output logic        alu_bsel_o,
  output logic [3:0]  alu_op_o,
  output logic        alu_signed_o,
  input  logic [31:0] alu_result_i,
  output logic [2:0]  imm_sel_o,
  output logic [31:0] inst_o,
  output logic        rf_we_o,
  output logic [1:0]  rf_wsel_o,
  output logic        pc_we_o,
  output logic [1:0]  pc_sel_o,
  output logic        halt_o,
  output logic        illegal_o,
  output logic [31:0] instret_o
);
  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, AND = 4'd2, OR = 4'd3, XOR = 4'd4,
                         SHL = 4'd5, SHR = 4'd6, SLT = 4'd7, PASS = 4'd8;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, WB, HALT} state_t;
  state_t      state_q, state_d;
  logic [31:0] inst_q, instret_q;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic        asel, bsel, sgn, legal, wr, mem, st, brk, br, jal, jalr, taken, act;
  logic [3:0]  op;
  logic [2:0]  imm;
  logic [1:0]  wsel;
  assign opc = inst_q[6:0];
  assign rd  = inst_q[11:7];
  assign f3  = inst_q[14:12];
  assign f7  = inst_q[31:25];
  always_comb begin
    asel  = 1'b0;
    bsel  = 1'b0;
    op    = ADD;
    sgn   = 1'b0;
    imm   = IMM_I;
    legal = 1'b0;
    wr    = 1'b0;
    wsel  = 2'd0;
    mem   = 1'b0;
    st    = 1'b0;
    brk   = 1'b0;
    br    = 1'b0;
    jal   = 1'b0;
    jalr  = 1'b0;
    case (opc)
      7'b0110111: begin legal = 1'b1; bsel = 1'b1; op = PASS; imm = IMM_U; wr = 1'b1; end
      7'b0010111: begin legal = 1'b1; asel = 1'b1; bsel = 1'b1; imm = IMM_U; wr = 1'b1; end
      7'b1101111: begin legal = 1'b1; asel = 1'b1; bsel = 1'b1; imm = IMM_J; wr = 1'b1; wsel = 2'd2; jal = 1'b1; end
      7'b1100111: begin legal = f3 == 3'b000; bsel = 1'b1; wr = 1'b1; wsel = 2'd2; jalr = 1'b1; end
      7'b1100011: begin
        legal = f3[2:1] != 2'b01;
        br    = 1'b1;
        imm   = IMM_B;
        op    = f3[2] ? SLT : SUB;
        sgn   = f3[2] & ~f3[1];
      end
      7'b0000011: begin legal = f3 != 3'b011 && f3[2:1] != 2'b11; mem = 1'b1; bsel = 1'b1; wr = 1'b1; wsel = 2'd1; end
      7'b0100011: begin legal = f3 < 3'd3; mem = 1'b1; st = 1'b1; bsel = 1'b1; imm = IMM_S; end
      7'b0010011, 7'b0110011: begin
        bsel  = ~opc[5];
        wr    = 1'b1;
        sgn   = f3 == 3'b010 || (f3 == 3'b101 && f7[5]);
        // register-register ops only accept the base and alternate (SUB/SRA) funct7 encodings
        legal = opc[5] ? (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
              : f3 == 3'b001 ? f7 == 7'h00
              : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
        case (f3)
          3'b000:         op = (opc[5] && f7[5]) ? SUB : ADD;
          3'b001:         op = SHL;
          3'b010, 3'b011: op = SLT;
          3'b100:         op = XOR;
          3'b101:         op = SHR;
          3'b110:         op = OR;
          default:        op = AND;
        endcase
      end
      7'b1110011: begin brk = inst_q == 32'h0010_0073; legal = brk; end
      default: ;
    endcase
  end
  assign taken = f3[2] ? (alu_result_i[0] ^ f3[0]) : ((alu_result_i == 32'd0) ^ f3[0]);
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = FETCH;
      FETCH:   state_d = ifu_ack_i ? EXEC : FETCH;
      EXEC:    state_d = (brk || !legal) ? HALT : mem ? MEM : WB;
      MEM:     state_d = lsu_ack_i ? WB : MEM;
      WB:      state_d = FETCH;
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      inst_q    <= '0;
      instret_q <= '0;
      ifu_req_o <= 1'b0;
      lsu_req_o <= 1'b0;
      lsu_wen_o <= 1'b0;
      pc_we_o   <= 1'b0;
      rf_we_o   <= 1'b0;
      rf_wsel_o <= 2'd0;
      pc_sel_o  <= 2'd0;
      halt_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      state_q   <= state_d;
      if (state_q == FETCH && ifu_ack_i) inst_q <= ifu_inst_i;
      if (state_q == WB) instret_q <= instret_q + 32'd1;
      ifu_req_o <= state_d == FETCH;
      lsu_req_o <= state_d == MEM;
      lsu_wen_o <= state_d == MEM && st;
      pc_we_o   <= state_d == WB;
      rf_we_o   <= state_d == WB && wr && rd != 5'd0;
      rf_wsel_o <= state_d == WB ? wsel : 2'd0;
      // branch outcome is taken from the ALU result seen in EXEC, on the way into WB
      pc_sel_o  <= state_d != WB ? 2'd0 : jalr ? 2'd2 : (jal || (br && taken)) ? 2'd1 : 2'd0;
      halt_o    <= state_d == HALT;
      illegal_o <= state_d == HALT && !legal;
    end
  end
  assign act          = state_q == EXEC || state_q == MEM || state_q == WB;
  assign alu_asel_o   = act & asel;
  assign alu_bsel_o   = act & bsel;
  assign alu_op_o     = act ? op : 4'd0;
  assign alu_signed_o = act & sgn;
  assign imm_sel_o    = act ? imm : 3'd0;
  assign inst_o       = inst_q;
  assign instret_o    = instret_q;
endmodule

// File: tb/tb_exec_ctrl.sv
// tb_exec_ctrl: table-driven scoreboard bench for the exec_ctrl sequencing FSM.
module tb_exec_ctrl;
  logic        clk, rst;
  logic        ifu_req_o, ifu_ack_i, lsu_req_o, lsu_wen_o, lsu_ack_i;
  logic [31:0] ifu_inst_i, alu_result_i, inst_o, instret_o;
  logic        alu_asel_o, alu_bsel_o, alu_signed_o, rf_we_o, pc_we_o, halt_o, illegal_o;
  logic [3:0]  alu_op_o;
  logic [2:0]  imm_sel_o;
  logic [1:0]  rf_wsel_o, pc_sel_o;
  int checks = 0, errors = 0, exp_instret = 0;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] res;
    int ifu_dly, lsu_dly, asel, bsel, op, sgn, imm, rf_we, wsel, psel, mem, wen, hlt, ill;
  } vec_t;
  vec_t vecs[18];
  vec_t exp_q[$];
  exec_ctrl dut (
    .clk(clk), .rst(rst),
    .ifu_req_o(ifu_req_o), .ifu_ack_i(ifu_ack_i), .ifu_inst_i(ifu_inst_i),
    .lsu_req_o(lsu_req_o), .lsu_wen_o(lsu_wen_o), .lsu_ack_i(lsu_ack_i),
    .alu_asel_o(alu_asel_o), .alu_bsel_o(alu_bsel_o), .alu_op_o(alu_op_o),
    .alu_signed_o(alu_signed_o), .alu_result_i(alu_result_i),
    .imm_sel_o(imm_sel_o), .inst_o(inst_o),
    .rf_we_o(rf_we_o), .rf_wsel_o(rf_wsel_o), .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o),
    .halt_o(halt_o), .illegal_o(illegal_o), .instret_o(instret_o)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic do_reset();
    rst = 1'b1;
    ifu_ack_i = 1'b0;
    lsu_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ifu_req", 32'(ifu_req_o), 0);
    chk("rst_halt", 32'(halt_o), 0);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_instret", instret_o, 0);
    chk("rst_inst", inst_o, 0);
    chk("rst_alu_op", 32'(alu_op_o), 0);
    rst = 1'b0;
    exp_instret = 0;
    @(negedge clk);
  endtask
  task automatic run(input vec_t v);
    vec_t e;
    int n, cnt;
    bit done;
    logic wen_seen, asel, bsel, sgn;
    logic [3:0] op;
    logic [2:0] imm;
    logic [31:0] li;
    exp_q.push_back(v);
    n = 0;
    while (!ifu_req_o && n < 20) begin @(negedge clk); n++; end
    chk("fetch_wait", 32'(ifu_req_o), 1);
    alu_result_i = v.res;
    repeat (v.ifu_dly) @(negedge clk);
    chk("fetch_hold", 32'(ifu_req_o), 1);
    ifu_ack_i = 1'b1;
    ifu_inst_i = v.inst;
    @(negedge clk);
    ifu_ack_i = 1'b0;
    ifu_inst_i = $urandom;
    asel = alu_asel_o; bsel = alu_bsel_o; op = alu_op_o; sgn = alu_signed_o; imm = imm_sel_o; li = inst_o;
    cnt = 0;
    done = 0;
    wen_seen = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (lsu_req_o) begin
        cnt++;
        wen_seen = lsu_wen_o;
        lsu_ack_i = cnt == v.lsu_dly + 1;
      end else lsu_ack_i = 1'b0;
      if (pc_we_o || halt_o) done = 1;
    end
    lsu_ack_i = 1'b0;
    e = exp_q.pop_front();
    chk("completed", 32'(done), 1);
    chk("inst_latch", li, e.inst);
    chk("halt", 32'(halt_o), 32'(e.hlt));
    chk("illegal", 32'(illegal_o), 32'(e.ill));
    if (e.hlt == 0) begin
      chk("alu_asel", 32'(asel), 32'(e.asel));
      chk("alu_bsel", 32'(bsel), 32'(e.bsel));
      chk("alu_op", 32'(op), 32'(e.op));
      chk("alu_signed", 32'(sgn), 32'(e.sgn));
      chk("imm_sel", 32'(imm), 32'(e.imm));
      chk("rf_we", 32'(rf_we_o), 32'(e.rf_we));
      chk("rf_wsel", 32'(rf_wsel_o), 32'(e.wsel));
      chk("pc_sel", 32'(pc_sel_o), 32'(e.psel));
      chk("lsu_cycles", 32'(cnt), 32'(e.mem != 0 ? e.lsu_dly + 1 : 0));
      if (e.mem != 0) chk("lsu_wen", 32'(wen_seen), 32'(e.wen));
      exp_instret++;
      @(negedge clk);
      chk("instret", instret_o, 32'(exp_instret));
      chk("wb_one_cycle", 32'(pc_we_o), 0);
    end else begin
      ifu_ack_i = 1'b1;
      lsu_ack_i = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("halt_ifu_req", 32'(ifu_req_o), 0);
        chk("halt_lsu_req", 32'(lsu_req_o), 0);
        chk("halt_we", 32'({rf_we_o, pc_we_o}), 0);
        chk("halt_alu_op", 32'(alu_op_o), 0);
        chk("halt_sticky", 32'({halt_o, illegal_o}), 32'({1'b1, e.ill[0]}));
      end
      do_reset();
    end
  endtask
  initial begin
    rst = 1'b1;
    ifu_ack_i = 1'b0;
    lsu_ack_i = 1'b0;
    ifu_inst_i = '0;
    alu_result_i = '0;
    vecs[0]  = '{32'h002081B3, 32'd0, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[1]  = '{32'h4032D293, 32'd0, 0, 0, 0, 1, 6, 1, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[2]  = '{32'h00208463, 32'd0, 1, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0};
    vecs[3]  = '{32'h00208463, 32'd5, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[4]  = '{32'h0000A183, 32'd0, 0, 3, 0, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
    vecs[5]  = '{32'h0020A223, 32'd0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0};
    vecs[6]  = '{32'h123453B7, 32'd0, 0, 0, 0, 1, 8, 0, 3, 1, 0, 0, 0, 0, 0, 0};
    vecs[7]  = '{32'h00001097, 32'd0, 0, 0, 1, 1, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0};
    vecs[8]  = '{32'h010000EF, 32'd0, 0, 0, 1, 1, 0, 0, 4, 1, 2, 1, 0, 0, 0, 0};
    vecs[9]  = '{32'h00008067, 32'd7, 0, 0, 0, 1, 0, 0, 0, 0, 2, 2, 0, 0, 0, 0};
    vecs[10] = '{32'h0020E463, 32'd1, 0, 0, 0, 0, 7, 0, 2, 0, 0, 1, 0, 0, 0, 0};
    vecs[11] = '{32'h0020D463, 32'd1, 0, 0, 0, 0, 7, 1, 2, 0, 0, 0, 0, 0, 0, 0};
    vecs[12] = '{32'h00513093, 32'd0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[13] = '{32'h402081B3, 32'd0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    vecs[14] = '{32'h00209463, 32'd5, 0, 0, 0, 0, 1, 0, 2, 0, 0, 1, 0, 0, 0, 0};
    vecs[15] = '{32'h00100073, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    vecs[16] = '{32'hFFFFFFFF, 32'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    vecs[17] = '{32'h022081B3, 32'd0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    do_reset();
    for (int i = 0; i < 18; i++) run(vecs[i]);
    run(vecs[0]);
    run(vecs[1]);
    chk("pre_rst_instret", instret_o, 2);
    ifu_ack_i = 1'b1;
    ifu_inst_i = 32'h002081B3;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ifu_ack_i = 1'b0;
    chk("midfetch_rst_ifu_req", 32'(ifu_req_o), 0);
    chk("midfetch_rst_instret", instret_o, 0);
    chk("midfetch_rst_inst", inst_o, 0);
    @(negedge clk);
    chk("midfetch_refetch", 32'(ifu_req_o), 1);
    @(negedge clk);
    chk("midfetch_ack_dropped", {31'd0, ifu_req_o} | inst_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule

// File: doc/exec_ctrl.md
EXEC_CTRL -- requirements
Module: exec_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL: ifu_req out 1 fetch request; ifu_ack in 1 fetch done; ifu_inst in 32 instruction, valid when ifu_ack=1.
REQ-004 SHALL: lsu_req out 1 memory request; lsu_wen out 1 store=1/load=0; lsu_ack in 1 access done.
REQ-005 SHALL: alu_asel out 1 (0=RS1, 1=PC); alu_bsel out 1 (0=RS2, 1=IMM); alu_op out 4; alu_signed out 1 (1=signed); alu_result in 32.
REQ-006 SHALL: alu_op codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SHIFL=5, SHIFR=6, SLT=7, PASS=8.
REQ-007 SHALL: imm_sel out 3 (I=0, S=1, B=2, U=3, J=4); inst out 32 latched instruction.
REQ-008 SHALL: rf_we out 1; rf_wsel out 2 (0=ALU, 1=MEM, 2=PC+4).
REQ-009 SHALL: pc_we out 1; pc_sel out 2 (0=PC+4, 1=PC+imm, 2=alu_result with bit0 cleared).
REQ-010 SHALL: halt out 1 sticky stop; illegal out 1 stop cause; instret out 32 retired-instruction count.

Function
REQ-011 SHALL: states IDLE, FETCH, EXEC, MEM, WB, HALT.
REQ-012 SHALL: IDLE->FETCH unconditionally next cycle.
REQ-013 SHALL: FETCH: ifu_req=1 every cycle; on ifu_ack=1 latch ifu_inst into inst and go to EXEC; otherwise stay.
REQ-014 SHALL: ifu_ack and lsu_ack outside FETCH and MEM respectively are ignored.
REQ-015 SHALL: EXEC lasts one cycle: load/store -> MEM; ebreak (0x00100073) -> HALT with illegal=0; unsupported opcode/funct -> HALT with illegal=1; else -> WB.
REQ-016 SHALL: MEM: lsu_req=1, lsu_wen=1 for store; hold until lsu_ack=1, then WB.
REQ-017 SHALL: WB lasts one cycle: pc_we=1, rf_we=1 if rd!=0 and instruction writes rd, instret+=1 (wraps 0xFFFFFFFF->0), then FETCH.
REQ-018 SHALL: alu_asel/bsel/op/signed and imm_sel decoded combinationally from inst, driven in EXEC, MEM, WB; all 0 in IDLE, FETCH, HALT.
REQ-019 SHALL: LUI: bsel=IMM, op=PASS, U; AUIPC: asel=PC, bsel=IMM, ADD, U; JAL: PC+IMM ADD, J, rf_wsel=2, pc_sel=1; JALR: RS1+IMM ADD, I, rf_wsel=2, pc_sel=2.
REQ-020 SHALL: load: RS1+IMM ADD, I, rf_wsel=1; store: RS1+IMM ADD, S, no rf_we.
REQ-021 SHALL: OP/OP-IMM funct3: 000 ADD (SUB if OP and funct7[5]); 001 SHIFL; 010 SLT signed; 011 SLT unsigned; 100 XOR; 101 SHIFR, signed=funct7[5]; 110 OR; 111 AND; OP-IMM uses bsel=IMM, I.
REQ-022 SHALL: branch: RS1 vs RS2, imm_sel=B, no rf_we; BEQ/BNE op=SUB, taken iff alu_result==0 / !=0; BLT/BGE SLT signed, BLTU/BGEU SLT unsigned, taken iff alu_result[0]==1 / ==0.
REQ-023 SHALL: in WB pc_sel=1 for taken branch or JAL, 2 for JALR, 0 otherwise.
REQ-024 SHALL: HALT is terminal until rst; halt=1, all request/write-enable outputs 0.

Reset
REQ-025 SHALL: rst=1 in any state (incl. mid-FETCH/MEM) -> next cycle IDLE, inst=0, instret=0, halt=0, illegal=0, all outputs 0; a pending ack is dropped.

Verification
REQ-026 SHALL: add x3,x1,x2 (0x002081B3), ifu_ack after 2 cycles -> EXEC alu_op=0, asel=0, bsel=0; WB rf_we=1, rf_wsel=0, pc_sel=0; instret=1.
REQ-027 SHALL: srai x5,x5,3 (0x4032D293) -> alu_op=6, alu_signed=1, bsel=1, imm_sel=0.
REQ-028 SHALL: beq x1,x2,+8 (0x00208463) with alu_result=0 -> pc_sel=1, rf_we=0; alu_result=5 -> pc_sel=0.
REQ-029 SHALL: lw (0x0000A183), lsu_ack delayed 3 cycles -> lsu_req high exactly 4 cycles, lsu_wen=0, then WB rf_wsel=1.
REQ-030 SHALL: inst 0xFFFFFFFF -> HALT, illegal=1, ifu_req=0 until rst; rst asserted mid-FETCH -> IDLE, instret=0.
